// File: rtl/sst_pkg.sv
// Shared types and default sizing for the save-state engine and its helpers.
package sst_pkg;

   localparam int unsigned SST_AW         = 8;
   localparam int unsigned SST_DW         = 8;
   localparam int unsigned SST_REG_CNT    = 256;
   localparam int unsigned SST_IDX_ADDR   = 127;
   localparam int unsigned SST_SETTLE     = 2;
   localparam int unsigned SST_M2_EDGES   = 2;
   localparam int unsigned SST_M2_TIMEOUT = 4096;

   typedef enum logic [2:0] {
      IDLE,
      SAVE_ADDR,
      CHK_FETCH,
      CHK_CMP,
      LD_FETCH,
      LD_HOLD,
      LD_GAP,
      DONE
   } sst_state_t;

endpackage

// File: rtl/m2_edge_det.sv
// Two-flop synchronizer for the raw CPU M2 clock plus a registered
// one-cycle pulse on each synchronized falling edge.
module m2_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic m2,
   output logic fall
);

   logic [1:0] sync;
   logic       prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '0;
         prev <= 1'b0;
         fall <= 1'b0;
      end else begin
         sync <= {sync[0], m2};
         prev <= sync[1];
         fall <= prev & ~sync[1];
      end
   end

endmodule

// File: rtl/sst_engine.sv
// Save-state initiator: saves mapper registers into an external buffer and
// replays them back, holding each write across synchronized M2 falling edges.
module sst_engine
   import sst_pkg::*;
#(
   parameter int unsigned REG_CNT    = SST_REG_CNT,
   parameter int unsigned IDX_ADDR   = SST_IDX_ADDR,
   parameter int unsigned SETTLE     = SST_SETTLE,
   parameter int unsigned M2_EDGES   = SST_M2_EDGES,
   parameter int unsigned M2_TIMEOUT = SST_M2_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              save_req,
   input  logic              load_req,
   input  logic              m2,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              sst_act,
   output logic [SST_AW-1:0] sst_addr,
   output logic              sst_we_reg,
   output logic [SST_DW-1:0] sst_dato,
   input  logic [SST_DW-1:0] sst_di,
   output logic [SST_AW-1:0] buf_addr,
   output logic              buf_we,
   output logic [SST_DW-1:0] buf_wdat,
   input  logic [SST_DW-1:0] buf_rdat
);

   localparam int unsigned SCW = $clog2(SETTLE + 1);
   localparam int unsigned ECW = $clog2(M2_EDGES + 1);
   localparam int unsigned TW  = $clog2(M2_TIMEOUT + 1);

   localparam logic [SST_AW-1:0] LAST_ADDR = SST_AW'(REG_CNT - 1);
   localparam logic [SST_AW-1:0] IDX       = SST_AW'(IDX_ADDR);

   sst_state_t state, state_d;

   logic [SST_AW-1:0] a, a_d;
   logic [SCW-1:0]    scnt, scnt_d;
   logic [ECW-1:0]    ecnt, ecnt_d;
   logic [TW-1:0]     tcnt, tcnt_d;

   logic              busy_d, done_d, err_d, sst_act_d, sst_we_reg_d, buf_we_d;
   logic [SST_AW-1:0] sst_addr_d, buf_addr_d;
   logic [SST_DW-1:0] sst_dato_d, buf_wdat_d;

   logic fall;
   logic last_byte;
   logic idx_bad;

   m2_edge_det u_m2_edge_det (
      .clk  (clk),
      .rst  (rst),
      .m2   (m2),
      .fall (fall)
   );

   assign last_byte = (a == LAST_ADDR);
   assign idx_bad   = (buf_rdat != sst_di);

   // State and all output/datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         a          <= '0;
         scnt       <= '0;
         ecnt       <= '0;
         tcnt       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         sst_act    <= 1'b0;
         sst_addr   <= '0;
         sst_we_reg <= 1'b0;
         sst_dato   <= '0;
         buf_addr   <= '0;
         buf_we     <= 1'b0;
         buf_wdat   <= '0;
      end else begin
         state      <= state_d;
         a          <= a_d;
         scnt       <= scnt_d;
         ecnt       <= ecnt_d;
         tcnt       <= tcnt_d;
         busy       <= busy_d;
         done       <= done_d;
         err        <= err_d;
         sst_act    <= sst_act_d;
         sst_addr   <= sst_addr_d;
         sst_we_reg <= sst_we_reg_d;
         sst_dato   <= sst_dato_d;
         buf_addr   <= buf_addr_d;
         buf_we     <= buf_we_d;
         buf_wdat   <= buf_wdat_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state;
      case (state)
         IDLE: begin
            if (save_req)      state_d = SAVE_ADDR;
            else if (load_req) state_d = CHK_FETCH;
         end
         SAVE_ADDR: begin
            if (scnt == SCW'(SETTLE) && last_byte) state_d = DONE;
         end
         CHK_FETCH: state_d = CHK_CMP;
         CHK_CMP:   state_d = idx_bad ? DONE : LD_FETCH;
         LD_FETCH:  state_d = LD_HOLD;
         LD_HOLD: begin
            if (fall) begin
               if (ecnt == ECW'(M2_EDGES - 1)) state_d = LD_GAP;
            end else if (tcnt == TW'(M2_TIMEOUT - 1)) begin
               state_d = DONE;
            end
         end
         LD_GAP:  state_d = last_byte ? DONE : LD_FETCH;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Register next-values for counters and outputs
   always_comb begin
      a_d          = a;
      scnt_d       = scnt;
      ecnt_d       = ecnt;
      tcnt_d       = tcnt;
      busy_d       = busy;
      err_d        = err;
      sst_act_d    = sst_act;
      sst_addr_d   = sst_addr;
      sst_we_reg_d = sst_we_reg;
      sst_dato_d   = sst_dato;
      buf_addr_d   = buf_addr;
      buf_we_d     = 1'b0;
      buf_wdat_d   = buf_wdat;

      case (state)
         IDLE: begin
            if (save_req || load_req) begin
               busy_d    = 1'b1;
               sst_act_d = 1'b1;
               err_d     = 1'b0;
               a_d       = '0;
               scnt_d    = '0;
               if (save_req) begin
                  sst_addr_d = '0;
               end else begin
                  sst_addr_d = IDX;
                  buf_addr_d = IDX;
               end
            end
         end
         SAVE_ADDR: begin
            if (scnt == SCW'(SETTLE - 1)) begin
               buf_we_d   = 1'b1;
               buf_addr_d = a;
               buf_wdat_d = sst_di;
               scnt_d     = scnt + SCW'(1);
            end else if (scnt == SCW'(SETTLE)) begin
               scnt_d = '0;
               if (!last_byte) begin
                  a_d        = a + SST_AW'(1);
                  sst_addr_d = a + SST_AW'(1);
               end
            end else begin
               scnt_d = scnt + SCW'(1);
            end
         end
         // Buffer read has one cycle of latency, so byte 0 is prefetched here
         CHK_FETCH: buf_addr_d = '0;
         CHK_CMP: begin
            if (idx_bad) begin
               err_d = 1'b1;
            end else begin
               a_d        = '0;
               sst_addr_d = '0;
            end
         end
         LD_FETCH: begin
            sst_dato_d   = buf_rdat;
            sst_we_reg_d = 1'b1;
            ecnt_d       = '0;
            tcnt_d       = '0;
         end
         LD_HOLD: begin
            if (fall) begin
               ecnt_d = ecnt + ECW'(1);
               tcnt_d = '0;
               if (ecnt == ECW'(M2_EDGES - 1)) begin
                  sst_we_reg_d = 1'b0;
                  buf_addr_d   = a + SST_AW'(1);
               end
            end else if (tcnt == TW'(M2_TIMEOUT - 1)) begin
               err_d        = 1'b1;
               sst_we_reg_d = 1'b0;
            end else begin
               tcnt_d = tcnt + TW'(1);
            end
         end
         LD_GAP: begin
            if (!last_byte) begin
               a_d        = a + SST_AW'(1);
               sst_addr_d = a + SST_AW'(1);
            end
         end
         DONE: begin
            busy_d     = 1'b0;
            sst_act_d  = 1'b0;
            sst_addr_d = '0;
         end
         default: ;
      endcase

      done_d = (state_d == DONE);
   end

endmodule

// File: tb/tb_sst_engine.sv
// Scoreboard bench for sst_engine: behavioural state buffer and mapper model,
// expected buffer writes and mapper write windows queued at stimulus time.
`timescale 1ns/1ps
module tb_sst_engine;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] dat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       save_req = 1'b0;
   logic       load_req = 1'b0;
   logic       m2 = 1'b0;
   logic       busy, done, err, sst_act, sst_we_reg, buf_we;
   logic [7:0] sst_addr, sst_dato, sst_di, buf_addr, buf_wdat;
   logic [7:0] buf_rdat = 8'h00;

   logic [7:0] mem  [256];
   logic [7:0] regs [256];
   logic       di_save = 1'b1;
   logic [7:0] map_idx = 8'h60;

   exp_t save_q[$];
   exp_t win_q[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int we_cnt = 0;
   int win_cnt = 0;
   int done_cnt = 0;
   int w_falls = 0;
   int bad_falls = 0;
   int bad_stable = 0;
   int hi_writes = 0;
   int stop_cyc = 0;
   int ph = 0;
   logic chk_falls = 1'b0;
   logic stop_arm = 1'b0;
   logic m2_run = 1'b0;
   logic m2_stop = 1'b0;
   logic we_q = 1'b0;
   logic [7:0] w_addr = 8'h00;
   logic [7:0] w_dat = 8'h00;

   always #5 clk = ~clk;

   sst_engine dut (
      .clk        (clk),
      .rst        (rst),
      .save_req   (save_req),
      .load_req   (load_req),
      .m2         (m2),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .sst_act    (sst_act),
      .sst_addr   (sst_addr),
      .sst_we_reg (sst_we_reg),
      .sst_dato   (sst_dato),
      .sst_di     (sst_di),
      .buf_addr   (buf_addr),
      .buf_we     (buf_we),
      .buf_wdat   (buf_wdat),
      .buf_rdat   (buf_rdat)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // State buffer: one-cycle read latency, write on buf_we
   always @(posedge clk) begin
      buf_rdat <= mem[buf_addr];
      if (buf_we) mem[buf_addr] = buf_wdat;
   end

   always @(posedge clk) cyc++;

   // Mapper model: captures writes on raw M2 falling edges
   assign sst_di = di_save ? (sst_addr ^ 8'h5A)
                           : ((sst_addr == 8'd127) ? map_idx : regs[sst_addr]);

   always @(negedge m2) begin
      if (sst_we_reg && sst_act) begin
         regs[sst_addr] = sst_dato;
         w_falls++;
         if (sst_addr >= 8'd4) hi_writes++;
      end
   end

   // M2: period 12 clk; once stopped it is left low after its natural fall
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (m2_run) begin
            ph++;
            if (ph == 6) begin
               ph = 0;
               if (m2 || !m2_stop) m2 = ~m2;
            end
         end
      end
   end

   // Buffer write scoreboard
   always @(negedge clk) begin
      if (!rst && buf_we) begin
         we_cnt++;
         if (save_q.size() == 0) begin
            chk("save_sb_nonempty", 32'(save_q.size()), 1);
         end else begin
            exp_t e;
            e = save_q.pop_front();
            chk("save_addr", 32'(buf_addr), 32'(e.addr));
            chk("save_data", 32'(buf_wdat), 32'(e.dat));
         end
      end
   end

   // Mapper write window scoreboard
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (sst_we_reg && !we_q) begin
         win_cnt++;
         w_addr  = sst_addr;
         w_dat   = sst_dato;
         w_falls = 0;
         if (win_q.size() == 0) begin
            chk("win_sb_nonempty", 32'(win_q.size()), 1);
         end else begin
            exp_t e;
            e = win_q.pop_front();
            chk("win_addr", 32'(sst_addr), 32'(e.addr));
            chk("win_data", 32'(sst_dato), 32'(e.dat));
         end
      end else if (sst_we_reg && we_q) begin
         if (sst_addr != w_addr || sst_dato != w_dat) bad_stable++;
      end else if (!sst_we_reg && we_q) begin
         if (chk_falls && (w_falls < 1 || w_falls > 2)) bad_falls++;
         if (stop_arm && w_addr == 8'd3 && !m2_stop) begin
            m2_stop  = 1'b1;
            stop_cyc = cyc;
         end
      end
      we_q = sst_we_reg;
   end

   task automatic run_req(input logic s, input logic l, input int budget, output int n);
      @(negedge clk);
      save_req = s;
      load_req = l;
      n = 0;
      @(negedge clk);
      save_req = 1'b0;
      load_req = 1'b0;
      n = 1;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", 32'(done), 1);
   endtask

   task automatic push_save();
      for (int i = 0; i < 256; i++) save_q.push_back({8'(i), 8'(i) ^ 8'h5A});
   endtask

   task automatic push_load();
      for (int i = 0; i < 256; i++) win_q.push_back({8'(i), mem[i]});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1);
   end

   initial begin
      int n, w0, e0, d0, k;
      for (int i = 0; i < 256; i++) begin
         mem[i]  = 8'h00;
         regs[i] = 8'h00;
      end

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_act", 32'(sst_act), 0);
      chk("rst_we_reg", 32'(sst_we_reg), 0);
      chk("rst_sst_addr", 32'(sst_addr), 0);
      chk("rst_buf_we", 32'(buf_we), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Save pass
      di_save = 1'b1;
      push_save();
      e0 = we_cnt;
      run_req(1'b1, 1'b0, 2000, n);
      chk("save_cycles", 32'(n), 769);
      chk("save_err", 32'(err), 0);
      chk("save_we_count", 32'(we_cnt - e0), 256);
      chk("save_buf0", 32'(mem[0]), 'h5A);
      chk("save_buf127", 32'(mem[127]), 'h25);
      chk("save_buf255", 32'(mem[255]), 'hA5);
      @(negedge clk);
      chk("save_idle_busy", 32'(busy), 0);
      chk("save_idle_act", 32'(sst_act), 0);

      // Load pass with matching index
      di_save = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
      mem[127] = 8'h60;
      m2_run = 1'b1;
      chk_falls = 1'b1;
      push_load();
      w0 = win_cnt;
      bad_falls = 0;
      bad_stable = 0;
      run_req(1'b0, 1'b1, 12000, n);
      chk("load_err", 32'(err), 0);
      chk("load_windows", 32'(win_cnt - w0), 256);
      chk("load_sb_drained", 32'(win_q.size()), 0);
      chk("load_falls_per_window", 32'(bad_falls), 0);
      chk("load_stable", 32'(bad_stable), 0);
      chk("load_reg0", 32'(regs[0]), 'h03);
      chk("load_reg1", 32'(regs[1]), 'h0A);
      chk("load_reg200", 32'(regs[200]), 32'(8'(200 * 7 + 3)));
      chk_falls = 1'b0;

      // Load with wrong mapper index
      mem[127] = 8'h61;
      w0 = win_cnt;
      run_req(1'b0, 1'b1, 20, n);
      chk("idx_latency_le4", 32'(n <= 4), 1);
      chk("idx_err", 32'(err), 1);
      chk("idx_no_writes", 32'(win_cnt - w0), 0);
      mem[127] = 8'h60;
      repeat (2) @(negedge clk);

      // Load with M2 stalled after addr 3
      for (int i = 0; i < 256; i++) regs[i] = 8'h00;
      push_load();
      w0 = win_cnt;
      hi_writes = 0;
      stop_arm = 1'b1;
      run_req(1'b0, 1'b1, 6000, n);
      chk("to_err", 32'(err), 1);
      chk("to_windows", 32'(win_cnt - w0), 5);
      chk("to_no_hi_writes", 32'(hi_writes), 0);
      chk("to_reg3", 32'(regs[3]), 'h18);
      chk("to_elapsed_ge", 32'((cyc - stop_cyc) >= 4096), 1);
      chk("to_elapsed_le", 32'((cyc - stop_cyc) <= 4200), 1);
      win_q.delete();
      stop_arm = 1'b0;
      m2_stop = 1'b0;
      repeat (4) @(negedge clk);

      // Simultaneous save and load requests, plus a load request mid-save
      di_save = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      push_save();
      w0 = win_cnt;
      e0 = we_cnt;
      fork
         run_req(1'b1, 1'b1, 2000, n);
         begin
            repeat (100) @(negedge clk);
            load_req = 1'b1;
            @(negedge clk);
            load_req = 1'b0;
         end
      join
      chk("both_cycles", 32'(n), 769);
      chk("both_err", 32'(err), 0);
      chk("both_we_count", 32'(we_cnt - e0), 256);
      chk("both_no_load", 32'(win_cnt - w0), 0);
      chk("both_buf200", 32'(mem[200]), 32'(8'd200 ^ 8'h5A));
      repeat (10) @(negedge clk);
      chk("both_idle_after", 32'(busy), 0);

      // Reset in the middle of a load hold
      di_save = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 5 + 1);
      mem[127] = 8'h60;
      push_load();
      @(negedge clk);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      k = 0;
      while (!(sst_we_reg && sst_addr == 8'd2) && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("rst_mid_reached_hold", 32'(sst_we_reg), 1);
      @(posedge clk);
      #3;
      d0 = done_cnt;
      rst = 1'b1;
      #1;
      chk("rst_mid_we_reg", 32'(sst_we_reg), 0);
      chk("rst_mid_act", 32'(sst_act), 0);
      chk("rst_mid_busy", 32'(busy), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mid_no_done", 32'(done_cnt - d0), 0);
      win_q.delete();
      push_load();
      w0 = win_cnt;
      run_req(1'b0, 1'b1, 12000, n);
      chk("rst_restart_err", 32'(err), 0);
      chk("rst_restart_windows", 32'(win_cnt - w0), 256);
      chk("rst_restart_reg0", 32'(regs[0]), 'h01);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
